lcd_frame_reader: RTL and testbench
===================================

LCD_FRAME_READER -- requirements
Module: lcd_frame_reader

Interface
REQ-001 SHALL have parameter H_DISP, default 12'd1024, active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 12'd600, active lines per frame.
REQ-003 SHALL have parameters H_SYNC/H_BACK/H_FRONT, defaults 20/140/160, horizontal timing in clocks.
REQ-004 SHALL have parameters V_SYNC/V_BACK/V_FRONT, defaults 3/20/12, vertical timing in lines.
REQ-005 SHALL define H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT and V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT.
REQ-006 Ports, in order:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- sys_vaild, input, 1: SDRAM controller ready.
- sys_rd_data, input, 24: read-FIFO pixel, valid one clk after sys_rd_en.
- sys_rd_load, output, 1: one-cycle pulse that (re)loads the read address range.
- sys_rd_addr_min, output, 32: frame start address.
- sys_rd_addr_max, output, 32: frame end address.
- sys_rd_en, output, 1: read-FIFO pop request.
- lcd_hs, output, 1: horizontal sync, active-low.
- lcd_vs, output, 1: vertical sync, active-low.
- lcd_de, output, 1: data enable.
- lcd_rgb, output, 24: pixel out.
- lcd_x, output, 12: active-region x.
- lcd_y, output, 12: active-region y.
- frame_done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-007 SHALL implement states IDLE, LOAD, RUN.
REQ-008 IDLE -> LOAD when sys_vaild=1; LOAD -> RUN unconditionally after 1 cycle.
REQ-009 RUN -> LOAD at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, with frame_done=1 in that same cycle; a frame therefore spans H_TOTAL*V_TOTAL+1 clocks.
REQ-010 Any state -> IDLE whenever sys_vaild=0; counters are cleared to 0, and all outputs go to their idle values from the next cycle.
REQ-011 sys_rd_load SHALL be 1 only in LOAD; sys_rd_addr_min=0 and sys_rd_addr_max=H_DISP*V_DISP, computed at 32-bit width, registered in LOAD and held thereafter.
REQ-012 h_cnt (12-bit) SHALL increment in RUN and wrap from H_TOTAL-1 to 0; v_cnt increments on each h_cnt wrap and wraps from V_TOTAL-1 to 0. Both are held at 0 in IDLE and LOAD.
REQ-013 Sync and active-region decode:
- lcd_hs=0 iff RUN and h_cnt<H_SYNC.
- lcd_vs=0 iff RUN and v_cnt<V_SYNC.
- h_act iff H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP.
- v_act iff V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_DISP.
REQ-014 sys_rd_en SHALL be combinational, =1 iff RUN, v_act, and h_cnt is within [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_DISP-2]; i.e. it leads h_act by one clock, so exactly H_DISP pops occur per active line.
REQ-015 lcd_de SHALL be registered: lcd_de(t+1) = sys_rd_en(t); lcd_rgb = lcd_de ? sys_rd_data : 24'h0.
REQ-016 lcd_x/lcd_y SHALL give the pixel position while lcd_de=1 (0..H_DISP-1, 0..V_DISP-1), and 0 otherwise.
REQ-017 Exactly H_DISP*V_DISP pops SHALL occur per complete frame; a frame aborted by sys_vaild=0 issues no further pops, and the next LOAD re-aligns the address.

Reset
REQ-018 On rst=1 (asynchronous), state SHALL be IDLE and h_cnt=v_cnt=0.
REQ-019 During and after reset, outputs SHALL be: sys_rd_load=0, sys_rd_en=0, lcd_de=0, lcd_rgb=0, lcd_x=lcd_y=0, frame_done=0, lcd_hs=lcd_vs=1, sys_rd_addr_min=0, sys_rd_addr_max=0.
REQ-020 Reset asserted mid-frame SHALL abort immediately; after release, the block proceeds per REQ-008.

Verification (H_DISP=4, V_DISP=2, all sync/porch=1: H_TOTAL=7, V_TOTAL=5)
REQ-021 rst released, sys_vaild=1 at cycle 0 -> sys_rd_load=1 in cycle 1 with addr_min=0 and addr_max=8; RUN starts in cycle 2 with h_cnt=0.
REQ-022 Full frame -> lcd_hs low for 1 clk in every 7; lcd_vs low for the first 7 RUN clocks; sys_rd_en high on h_cnt 1..4 of lines 2..3 (8 pops total); lcd_de high on h_cnt 2..5 of those lines.
REQ-023 sys_rd_data returns 0,1,...,7 in pop order -> lcd_rgb shows 0..7 with (lcd_x, lcd_y) = (0,0)..(3,1); lcd_rgb=0 whenever lcd_de=0.
REQ-024 End of frame -> frame_done=1 for exactly 1 clk at h=6, v=4; the next cycle sys_rd_load=1; the frame period is 36 clocks.
REQ-025 sys_vaild dropped at the 3rd pop -> no further sys_rd_en, lcd_de=0, state IDLE; sys_vaild restored -> LOAD, then a fresh frame with 8 pops.
REQ-026 rst pulsed mid-line -> all outputs immediately go to the REQ-019 values; after release, frame timing restarts from REQ-021.

Source files
------------

// File: rtl/lcd_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_frame_reader                                             |
// | Description : LCD timing generator that pops pixels from an SDRAM read     |
// |               FIFO, emitting hs/vs/de/rgb plus active-region x/y and an    |
// |               end-of-frame pulse. Reloads the read range once per frame.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcd_frame_reader #(
  parameter logic [11:0] H_DISP  = 12'd1024,
  parameter logic [11:0] V_DISP  = 12'd600,
  parameter logic [11:0] H_SYNC  = 12'd20,
  parameter logic [11:0] H_BACK  = 12'd140,
  parameter logic [11:0] H_FRONT = 12'd160,
  parameter logic [11:0] V_SYNC  = 12'd3,
  parameter logic [11:0] V_BACK  = 12'd20,
  parameter logic [11:0] V_FRONT = 12'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sys_vaild,
  input  logic [23:0] sys_rd_data,
  output logic        sys_rd_load,
  output logic [31:0] sys_rd_addr_min,
  output logic [31:0] sys_rd_addr_max,
  output logic        sys_rd_en,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic [11:0] lcd_x,
  output logic [11:0] lcd_y,
  output logic        frame_done
);

  localparam logic [11:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [11:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  // Active window bounds (end values are exclusive)
  localparam logic [11:0] c_h_act_beg = H_SYNC + H_BACK;
  localparam logic [11:0] c_h_act_end = H_SYNC + H_BACK + H_DISP;
  localparam logic [11:0] c_v_act_beg = V_SYNC + V_BACK;
  localparam logic [11:0] c_v_act_end = V_SYNC + V_BACK + V_DISP;

  // FIFO pops run one clock ahead of the active window (inclusive bounds)
  localparam logic [11:0] c_h_rd_beg  = c_h_act_beg - 12'd1;
  localparam logic [11:0] c_h_rd_end  = c_h_act_end - 12'd2;

  localparam logic [31:0] c_addr_max  = 32'(H_DISP) * 32'(V_DISP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_de;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [31:0] r_addr_max;

  logic        w_run;
  logic        w_frame_end;
  logic        w_v_act;
  logic        w_rd_en;

  assign w_run       = (r_state == ST_RUN);
  assign w_frame_end = w_run && (r_h_cnt == H_TOTAL - 12'd1) && (r_v_cnt == V_TOTAL - 12'd1);
  assign w_v_act     = (r_v_cnt >= c_v_act_beg) && (r_v_cnt < c_v_act_end);
  assign w_rd_en     = w_run && w_v_act && (r_h_cnt >= c_h_rd_beg) && (r_h_cnt <= c_h_rd_end);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; losing the SDRAM ready overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_RUN;
      ST_RUN:  if (w_frame_end) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!sys_vaild) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Raster counters: advance only while running, otherwise parked at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else if (!sys_vaild || !w_run) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else if (r_h_cnt == H_TOTAL - 12'd1) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= (r_v_cnt == V_TOTAL - 12'd1) ? 12'd0 : r_v_cnt + 12'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  // Capture the read range on entry to LOAD so it is already valid during the load pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_max <= 32'd0;
    end else if (w_state_nxt == ST_LOAD) begin
      r_addr_max <= c_addr_max;
    end
  end

  // Pixel pipeline: data enable and coordinates line up with the FIFO's one-clock read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de <= 1'b0;
      r_x  <= 12'd0;
      r_y  <= 12'd0;
    end else if (sys_vaild && w_rd_en) begin
      r_de <= 1'b1;
      r_x  <= r_h_cnt - c_h_rd_beg;
      r_y  <= r_v_cnt - c_v_act_beg;
    end else begin
      r_de <= 1'b0;
      r_x  <= 12'd0;
      r_y  <= 12'd0;
    end
  end

  assign sys_rd_load     = (r_state == ST_LOAD);
  assign sys_rd_addr_min = 32'd0;
  assign sys_rd_addr_max = r_addr_max;
  assign sys_rd_en       = w_rd_en;
  assign lcd_hs          = !(w_run && (r_h_cnt < H_SYNC));
  assign lcd_vs          = !(w_run && (r_v_cnt < V_SYNC));
  assign lcd_de          = r_de;
  assign lcd_rgb         = r_de ? sys_rd_data : 24'h0;
  assign lcd_x           = r_x;
  assign lcd_y           = r_y;
  assign frame_done      = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lcd_frame_reader                                          |
// | Description : Self-checking bench for lcd_frame_reader on a tiny 4x2       |
// |               raster (H_TOTAL=7, V_TOTAL=5, frame period 36 clocks).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lcd_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sys_vaild = 1'b0;
  logic [23:0] sys_rd_data = 24'hABCDEF;
  logic        sys_rd_load;
  logic [31:0] sys_rd_addr_min;
  logic [31:0] sys_rd_addr_max;
  logic        sys_rd_en;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic [11:0] lcd_x;
  logic [11:0] lcd_y;
  logic        frame_done;

  lcd_frame_reader #(
    .H_DISP(12'd4), .V_DISP(12'd2),
    .H_SYNC(12'd1), .H_BACK(12'd1), .H_FRONT(12'd1),
    .V_SYNC(12'd1), .V_BACK(12'd1), .V_FRONT(12'd1)
  ) dut (
    .clk(clk), .rst(rst), .sys_vaild(sys_vaild), .sys_rd_data(sys_rd_data),
    .sys_rd_load(sys_rd_load), .sys_rd_addr_min(sys_rd_addr_min),
    .sys_rd_addr_max(sys_rd_addr_max), .sys_rd_en(sys_rd_en),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .lcd_x(lcd_x), .lcd_y(lcd_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Model: number of consecutive clock edges with ready high and no reset
  int m_k = 0;
  initial begin
    forever begin
      @(posedge clk);
      if (rst || !sys_vaild) m_k = 0;
      else m_k = m_k + 1;
    end
  end

  // Per-cycle comparison against the raster model derived from m_k
  initial begin
    int j, t, h, v, p_h, p_v, e_x, e_y;
    bit idle, e_load, e_run, e_en, e_de, e_done, p_en, m_loaded;
    p_en = 0; p_h = 0; p_v = 0; m_loaded = 0;
    forever begin
      @(negedge clk);
      idle   = rst || (m_k == 0);
      j      = idle ? 0 : (m_k - 1) % 36;
      e_load = !idle && (j == 0);
      e_run  = !idle && (j != 0);
      t      = j - 1;
      h      = e_run ? t % 7 : 0;
      v      = e_run ? t / 7 : 0;
      e_en   = e_run && v >= 2 && v <= 3 && h >= 1 && h <= 4;
      e_done = e_run && h == 6 && v == 4;
      e_de   = p_en && !idle;
      e_x    = e_de ? p_h - 1 : 0;
      e_y    = e_de ? p_v - 2 : 0;
      if (rst) m_loaded = 0;
      else if (e_load) m_loaded = 1;
      chk("load",  32'(sys_rd_load), 32'(e_load));
      chk("rd_en", 32'(sys_rd_en), 32'(e_en));
      chk("hs",    32'(lcd_hs), 32'(!(e_run && h < 1)));
      chk("vs",    32'(lcd_vs), 32'(!(e_run && v < 1)));
      chk("done",  32'(frame_done), 32'(e_done));
      chk("de",    32'(lcd_de), 32'(e_de));
      chk("x",     32'(lcd_x), 32'(e_x));
      chk("y",     32'(lcd_y), 32'(e_y));
      chk("rgb",   32'(lcd_rgb), e_de ? 32'(e_y * 4 + e_x) : 32'd0);
      chk("amin",  sys_rd_addr_min, 32'd0);
      chk("amax",  sys_rd_addr_max, m_loaded ? 32'd8 : 32'd0);
      p_en = e_en; p_h = h; p_v = v;
    end
  end

  // Read FIFO: answers each pop one clock later with its index within the frame
  initial begin
    int  pop;
    logic en_s, ld_s;
    pop = 0;
    forever begin
      @(negedge clk);
      en_s = sys_rd_en;
      ld_s = sys_rd_load;
      @(posedge clk);
      #1;
      if (ld_s) pop = 0;
      if (en_s) begin
        sys_rd_data = 24'(pop);
        pop = pop + 1;
      end else begin
        sys_rd_data = 24'hABCDEF;
      end
    end
  end

  // Window statistics for the hand-computed frame expectations
  int mc, n_en, n_de, n_hs, n_vs, n_done, done_idx;
  logic [31:0] first_addr;
  int loadq[$];
  logic [23:0] rgbq[$];
  logic [11:0] xq[$];
  logic [11:0] yq[$];

  task automatic stat_clear();
    mc = 0; n_en = 0; n_de = 0; n_hs = 0; n_vs = 0; n_done = 0; done_idx = -1;
    first_addr = 32'hFFFFFFFF;
    loadq.delete(); rgbq.delete(); xq.delete(); yq.delete();
  endtask

  initial begin
    stat_clear();
    forever begin
      @(negedge clk);
      if (sys_rd_en) n_en++;
      if (lcd_de) begin
        n_de++;
        rgbq.push_back(lcd_rgb); xq.push_back(lcd_x); yq.push_back(lcd_y);
      end
      if (!lcd_hs) n_hs++;
      if (!lcd_vs) n_vs++;
      if (frame_done) begin n_done++; done_idx = mc; end
      if (sys_rd_load) begin
        if (loadq.size() == 0) first_addr = sys_rd_addr_max;
        loadq.push_back(mc);
      end
      mc++;
    end
  end

  // Run one full frame window starting with the first LOAD at index l0, then check it
  task automatic run_frame(input string tag, input int l0);
    repeat (l0 + 37) @(negedge clk);
    #1;
    chk({tag, " loads"},   32'(loadq.size()), 32'd2);
    chk({tag, " load0"},   (loadq.size() > 0) ? 32'(loadq[0]) : 32'hFFFFFFFF, 32'(l0));
    chk({tag, " load1"},   (loadq.size() > 1) ? 32'(loadq[1]) : 32'hFFFFFFFF, 32'(l0 + 36));
    chk({tag, " addr"},    first_addr, 32'd8);
    chk({tag, " done_n"},  32'(n_done), 32'd1);
    chk({tag, " done_at"}, 32'(done_idx), 32'(l0 + 35));
    chk({tag, " pops"},    32'(n_en), 32'd8);
    chk({tag, " de_n"},    32'(n_de), 32'd8);
    chk({tag, " hs_low"},  32'(n_hs), 32'd5);
    chk({tag, " vs_low"},  32'(n_vs), 32'd7);
    for (int i = 0; i < 8; i++) begin
      chk({tag, " pix_rgb"}, (i < rgbq.size()) ? 32'(rgbq[i]) : 32'hFFFFFFFF, 32'(i));
      chk({tag, " pix_x"},   (i < xq.size())   ? 32'(xq[i])   : 32'hFFFFFFFF, 32'(i % 4));
      chk({tag, " pix_y"},   (i < yq.size())   ? 32'(yq[i])   : 32'hFFFFFFFF, 32'(i / 4));
    end
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hs", 32'(lcd_hs), 32'd1);
    chk("reset vs", 32'(lcd_vs), 32'd1);

    // Release reset with ready high: IDLE in cycle 0, LOAD in cycle 1
    @(posedge clk);
    #1;
    rst = 1'b0;
    sys_vaild = 1'b1;
    stat_clear();
    run_frame("frame1", 1);

    // Second frame already loading; drop ready just before the third pop's edge
    stat_clear();
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (n_en == 3) seen = 1;
    end
    chk("third pop seen", 32'(seen), 32'd1);
    sys_vaild = 1'b0;
    stat_clear();
    repeat (10) @(negedge clk);
    #1;
    chk("abort pops", 32'(n_en), 32'd0);
    chk("abort de",   32'(n_de), 32'd0);
    chk("abort load", 32'(loadq.size()), 32'd0);

    // Restore ready: LOAD in the very next cycle, then a fresh full frame
    sys_vaild = 1'b1;
    stat_clear();
    run_frame("restore", 0);

    // Reset in the middle of an active line
    repeat (24) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst rd_en", 32'(sys_rd_en), 32'd0);
    chk("midrst de",    32'(lcd_de), 32'd0);
    chk("midrst rgb",   32'(lcd_rgb), 32'd0);
    chk("midrst hs",    32'(lcd_hs), 32'd1);
    chk("midrst vs",    32'(lcd_vs), 32'd1);
    chk("midrst amax",  sys_rd_addr_max, 32'd0);
    chk("midrst x",     32'(lcd_x), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stat_clear();
    run_frame("postrst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
